// File: rtl/sram_frame_reader.sv
// Read-side initiator for the 1RW1R SRAM: issues burst reads on the read port,
// tracks the fixed two-cycle latency and streams words out through a 4-deep FWFT FIFO.
module sram_frame_reader #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ASIZE-1:0] base_addr,
  input  logic [ASIZE:0]   length,
  output logic             mem_cs_n,
  output logic [ASIZE-1:0] mem_addr,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             pix_valid,
  output logic [DSIZE-1:0] pix_data,
  output logic             pix_last,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done
);

  // Output handshake: a word transfers in any cycle where pix_valid and pix_ready
  // are both 1; while pix_valid=1 and pix_ready=0 the word and its last flag hold.
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [ASIZE-1:0] base_q, base_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [ASIZE:0]   len_q, len_d;
  logic [ASIZE:0]   issued_q, issued_d, issued_nxt;
  logic [1:0]       pv_q, pv_d;
  logic [1:0]       pl_q, pl_d;
  logic             done_q, done_d;
  logic [DSIZE-1:0] fifo_data_q [4];
  logic [3:0]       fifo_last_q;
  logic [1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       inflight;
  logic             credit, issue, issue_last, push, pop, bypass;

  assign issued_nxt = issued_q + (ASIZE+1)'(1);
  assign issue_last = (issued_nxt == len_q);
  assign inflight   = {2'b00, pv_q[0]} + {2'b00, pv_q[1]};
  // Reads already in flight reserve a FIFO slot, so back-pressure can never overflow it.
  assign credit     = (cnt_q + inflight) < 3'd4;

  // An arriving word falls straight through when the FIFO is empty.
  assign push      = pv_q[1];
  assign bypass    = (cnt_q == 3'd0) && pv_q[1];
  assign pix_valid = (cnt_q != 3'd0) || pv_q[1];
  assign pix_data  = bypass ? mem_rdata : fifo_data_q[rd_q];
  assign pix_last  = pix_valid && (bypass ? pl_q[1] : fifo_last_q[rd_q]);
  assign pop       = pix_valid && pix_ready;

  assign mem_cs_n = ~issue;
  assign mem_addr = addr_d;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          if (length != '0) state_d = READ;
          else              done_d  = 1'b1;
        end
      end
      READ: begin
        if (credit) begin
          issue    = 1'b1;
          issued_d = issued_nxt;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && pix_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = issue ? (base_q + issued_q[ASIZE-1:0]) : addr_q;
    pv_d   = {pv_q[0], issue};
    pl_d   = {pl_q[0], issue & issue_last};
    wr_d   = wr_q + {1'b0, push};
    rd_d   = rd_q + {1'b0, pop};
    cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pv_q        <= '0;
      pl_q        <= '0;
      done_q      <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < 4; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      pv_q     <= pv_d;
      pl_q     <= pl_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      if (push) begin
        fifo_data_q[wr_q] <= mem_rdata;
        fifo_last_q[wr_q] <= pl_q[1];
      end
    end
  end

endmodule
